// File: rtl/mc_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_defs (package)
//  Purpose  : Shared definitions for the multicycle main controller: opcode
//             and funct field values, ALU operation codes (shared with the
//             ALU), datapath selector encodings and the controller states.
//  Revision : 1.0  initial release
// ============================================================================
package mc_defs;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_XOR = 6'b100110;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;
    localparam logic [2:0] c_ALU_NOT = 3'b101;
    localparam logic [2:0] c_ALU_NOR = 3'b110;
    localparam logic [2:0] c_ALU_XOR = 3'b111;

    // ALU operand B selector
    localparam logic [1:0] c_SRCB_REGB    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    // PC source selector
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_EXC    = 2'b11;

    // Controller states; encodings 13..15 are unused
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MADR   = 4'd2,
        ST_MRD    = 4'd3,
        ST_MWB    = 4'd4,
        ST_MWR    = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_IEXEC  = 4'd8,
        ST_IWB    = 4'd9,
        ST_BR     = 4'd10,
        ST_JMP    = 4'd11,
        ST_EXC    = 4'd12
    } state_t;

endpackage : mc_defs
`default_nettype wire

// File: rtl/mc_ctrl_alu_dec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_dec
//  Purpose  : R-type funct field to ALU operation decoder.
//  Ports    : funct_i       - IR[5:0]
//             alu_ctrl_o    - ALU operation code (AND when funct is unknown)
//             funct_valid_o - funct is a supported R-type operation
//             addsub_o      - funct is add or sub (overflow-checked ops)
//  Revision : 1.0  initial release
// ============================================================================
module alu_dec
    import mc_defs::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_valid_o,
    output logic       addsub_o
);

    always_comb begin
        alu_ctrl_o    = c_ALU_AND;
        funct_valid_o = 1'b1;
        addsub_o      = 1'b0;
        case (funct_i)
            c_FN_AND: alu_ctrl_o = c_ALU_AND;
            c_FN_OR:  alu_ctrl_o = c_ALU_OR;
            c_FN_ADD: begin alu_ctrl_o = c_ALU_ADD; addsub_o = 1'b1; end
            c_FN_SUB: begin alu_ctrl_o = c_ALU_SUB; addsub_o = 1'b1; end
            c_FN_SLT: alu_ctrl_o = c_ALU_SLT;
            c_FN_NOR: alu_ctrl_o = c_ALU_NOR;
            c_FN_XOR: alu_ctrl_o = c_ALU_XOR;
            default:  funct_valid_o = 1'b0;
        endcase
    end

endmodule : alu_dec
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multicycle main controller. Steps each instruction through
//             fetch/decode/execute/memory/writeback, drives the ALU code and
//             datapath controls, and traps on overflow or illegal opcodes.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             op, funct           - IR opcode and function fields
//             Zero, OF            - ALU flags (same-cycle)
//             ALUCtrl             - ALU operation code
//             alu_src_a/_b        - ALU operand selectors
//             pc_write, pc_src    - PC load enable and source select
//             iord                - memory address select
//             mem_write, ir_write - memory write, IR load
//             reg_dst, mem_to_reg - regfile destination / data select
//             reg_write, exc      - regfile write, exception pulse
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
    import mc_defs::*;
#(
    parameter bit EXC_ON_OVF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       OF,
    output logic [2:0] ALUCtrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       exc
);

    state_t     state_q;
    state_t     state_d;
    state_t     w_out_state;
    logic [2:0] w_fn_ctrl;
    logic       w_fn_valid;
    logic       w_fn_addsub;

    alu_dec u_alu_dec (
        .funct_i       (funct),
        .alu_ctrl_o    (w_fn_ctrl),
        .funct_valid_o (w_fn_valid),
        .addsub_o      (w_fn_addsub)
    );

    // Next-state logic
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: state_d = ST_MADR;
                    c_OP_RTYPE:       state_d = ST_EXEC;
                    c_OP_BEQ:         state_d = ST_BR;
                    c_OP_ADDI:        state_d = ST_IEXEC;
                    c_OP_J:           state_d = ST_JMP;
                    default:          state_d = ST_EXC;
                endcase
            end
            ST_MADR:   state_d = (op == c_OP_LW) ? ST_MRD : ST_MWR;
            ST_MRD:    state_d = ST_MWB;
            ST_EXEC: begin
                if (!w_fn_valid)
                    state_d = ST_EXC;
                else if (EXC_ON_OVF && w_fn_addsub && OF)
                    state_d = ST_EXC;
                else
                    state_d = ST_RWB;
            end
            ST_IEXEC:  state_d = (EXC_ON_OVF && OF) ? ST_EXC : ST_IWB;
            // MWB, MWR, RWB, IWB, BR, JMP, EXC and unused encodings
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While in reset the outputs present FETCH values so the datapath sees a
    // consistent selector set, but every enable is masked below.
    assign w_out_state = rst ? ST_FETCH : state_q;

    always_comb begin
        ALUCtrl    = c_ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = c_SRCB_REGB;
        pc_write   = 1'b0;
        pc_src     = c_PCSRC_ALU;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        exc        = 1'b0;
        case (w_out_state)
            ST_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = c_SRCB_FOUR;
                ALUCtrl   = c_ALU_ADD;
                pc_src    = c_PCSRC_ALU;
                pc_write  = 1'b1;
            end
            ST_DECODE: begin
                // Branch target computed speculatively into ALUOut
                alu_src_b = c_SRCB_IMM_SH2;
                ALUCtrl   = c_ALU_ADD;
            end
            ST_MADR, ST_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                ALUCtrl   = c_ALU_ADD;
            end
            ST_MRD: iord = 1'b1;
            ST_MWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            ST_MWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_REGB;
                ALUCtrl   = w_fn_ctrl;
            end
            ST_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_IWB: reg_write = 1'b1;
            ST_BR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_REGB;
                ALUCtrl   = c_ALU_SUB;
                pc_src    = c_PCSRC_ALUOUT;
                pc_write  = Zero;
            end
            ST_JMP: begin
                pc_src   = c_PCSRC_JUMP;
                pc_write = 1'b1;
            end
            ST_EXC: begin
                exc      = 1'b1;
                pc_src   = c_PCSRC_EXC;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            exc       = 1'b0;
        end
    end

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl. Two instances run side by side
//             (overflow trapping enabled and disabled) and every cycle of
//             every instruction is compared with a reference model that
//             derives the expected phase sequence from the instruction class.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       pcw;
        logic [1:0] pcs;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       exc;
    } outs_t;

    typedef enum int {
        P_FETCH, P_DECODE, P_MADR, P_MRD, P_MWB, P_MWR,
        P_EXEC, P_RWB, P_IEXEC, P_IWB, P_BR, P_JMP, P_EXC
    } phase_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       Zero, OF;

    logic [2:0] alu1, alu0;
    logic       sa1, sa0, pcw1, pcw0, iord1, iord0, mw1, mw0, irw1, irw0;
    logic       rd1, rd0, m2r1, m2r0, rw1, rw0, exc1, exc0;
    logic [1:0] sb1, sb0, pcs1, pcs0;
    outs_t      obs1, obs0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.EXC_ON_OVF(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero), .OF(OF),
        .ALUCtrl(alu1), .alu_src_a(sa1), .alu_src_b(sb1), .pc_write(pcw1),
        .pc_src(pcs1), .iord(iord1), .mem_write(mw1), .ir_write(irw1),
        .reg_dst(rd1), .mem_to_reg(m2r1), .reg_write(rw1), .exc(exc1)
    );

    mc_ctrl #(.EXC_ON_OVF(1'b0)) dut_noovf (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero), .OF(OF),
        .ALUCtrl(alu0), .alu_src_a(sa0), .alu_src_b(sb0), .pc_write(pcw0),
        .pc_src(pcs0), .iord(iord0), .mem_write(mw0), .ir_write(irw0),
        .reg_dst(rd0), .mem_to_reg(m2r0), .reg_write(rw0), .exc(exc0)
    );

    assign obs1 = {alu1, sa1, sb1, pcw1, pcs1, iord1, mw1, irw1, rd1, m2r1, rw1, exc1};
    assign obs0 = {alu0, sa0, sb0, pcw0, pcs0, iord0, mw0, irw0, rd0, m2r0, rw0, exc0};

    // ---------------- reference model ----------------
    function automatic logic fn_valid(input logic [5:0] f);
        case (f)
            6'b100100, 6'b100101, 6'b100000, 6'b100010,
            6'b101010, 6'b100111, 6'b100110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] fn_code(input logic [5:0] f);
        case (f)
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100000: return 3'b010;
            6'b100010: return 3'b011;
            6'b101010: return 3'b100;
            6'b100111: return 3'b110;
            6'b100110: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
               (o == OP_ADDI) || (o == OP_J);
    endfunction

    // Instruction latency in cycles, by class
    function automatic int seq_len(input logic [5:0] o);
        case (o)
            OP_LW:                   return 5;
            OP_SW, OP_R, OP_ADDI:    return 4;
            default:                 return 3;
        endcase
    endfunction

    // Phase occupied at cycle k of an instruction; exec_of is OF during the
    // execute cycle, en selects whether overflow traps.
    function automatic phase_t seq_at(input logic [5:0] o, input logic [5:0] f,
                                      input logic exec_of, input logic en, input int k);
        if (k == 0) return P_FETCH;
        if (k == 1) return P_DECODE;
        case (o)
            OP_LW:   return (k == 2) ? P_MADR : ((k == 3) ? P_MRD : P_MWB);
            OP_SW:   return (k == 2) ? P_MADR : P_MWR;
            OP_R: begin
                if (k == 2) return P_EXEC;
                if (!fn_valid(f) || (en && exec_of && (f == F_ADD || f == F_SUB)))
                    return P_EXC;
                return P_RWB;
            end
            OP_ADDI: begin
                if (k == 2) return P_IEXEC;
                return (en && exec_of) ? P_EXC : P_IWB;
            end
            OP_BEQ:  return P_BR;
            OP_J:    return P_JMP;
            default: return P_EXC;
        endcase
    endfunction

    function automatic outs_t phase_out(input phase_t p, input logic [5:0] f, input logic z);
        outs_t e;
        e = '0;
        case (p)
            P_FETCH:  begin e.alu = 3'b010; e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1; end
            P_DECODE: begin e.alu = 3'b010; e.srcb = 2'b11; end
            P_MADR:   begin e.alu = 3'b010; e.srca = 1'b1; e.srcb = 2'b10; end
            P_MRD:    e.iord = 1'b1;
            P_MWB:    begin e.m2r = 1'b1; e.rw = 1'b1; end
            P_MWR:    begin e.iord = 1'b1; e.mw = 1'b1; end
            P_EXEC:   begin e.alu = fn_code(f); e.srca = 1'b1; end
            P_RWB:    begin e.rdst = 1'b1; e.rw = 1'b1; end
            P_IEXEC:  begin e.alu = 3'b010; e.srca = 1'b1; e.srcb = 2'b10; end
            P_IWB:    e.rw = 1'b1;
            P_BR:     begin e.alu = 3'b011; e.srca = 1'b1; e.pcs = 2'b01; e.pcw = z; end
            P_JMP:    begin e.pcs = 2'b10; e.pcw = 1'b1; end
            P_EXC:    begin e.exc = 1'b1; e.pcs = 2'b11; e.pcw = 1'b1; end
            default:  ;
        endcase
        return e;
    endfunction

    function automatic outs_t reset_out();
        outs_t e;
        e = phase_out(P_FETCH, 6'd0, 1'b0);
        e.pcw = 1'b0;
        e.irw = 1'b0;
        return e;
    endfunction

    // Runs one instruction from its FETCH cycle, comparing both instances
    // every cycle. force_of/force_zero < 0 means random in the execute/branch
    // cycle. Starts just after a falling edge, returns on a falling edge.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int force_of, input int force_zero,
                             output int e1, output int w1, output int e0,
                             output int w0, output int m1, output int p1);
        logic   ofv [5];
        phase_t ph1, ph0;
        outs_t  x1, x0, g1, g0;
        int     len;
        e1 = 0; w1 = 0; e0 = 0; w0 = 0; m1 = 0; p1 = 0;
        for (int i = 0; i < 5; i++) ofv[i] = 1'($urandom_range(0, 1));
        if (force_of >= 0) ofv[2] = (force_of != 0);
        len   = seq_len(o);
        op    = o;
        funct = f;
        for (int k = 0; k < len; k++) begin
            OF   = ofv[k];
            Zero = 1'($urandom_range(0, 1));
            if (k == 2 && force_zero >= 0) Zero = (force_zero != 0);
            #1;
            ph1 = seq_at(o, f, ofv[2], 1'b1, k);
            ph0 = seq_at(o, f, ofv[2], 1'b0, k);
            x1 = phase_out(ph1, f, Zero);
            x0 = phase_out(ph0, f, Zero);
            g1 = obs1;
            g0 = obs0;
            // ALU code for an unsupported funct is not defined
            if (ph1 == P_EXEC && !fn_valid(f)) g1.alu = x1.alu;
            if (ph0 == P_EXEC && !fn_valid(f)) g0.alu = x0.alu;
            n_vec++;
            if (g1 !== x1) begin
                n_err++;
                $display("FAIL cycle ovf_en=1 op=%b funct=%b k=%0d: got %h expected %h",
                         o, f, k, g1, x1);
            end
            n_vec++;
            if (g0 !== x0) begin
                n_err++;
                $display("FAIL cycle ovf_en=0 op=%b funct=%b k=%0d: got %h expected %h",
                         o, f, k, g0, x0);
            end
            e1 += int'(exc1); w1 += int'(rw1); e0 += int'(exc0);
            w0 += int'(rw0);  m1 += int'(mw1); p1 += int'(pcw1);
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; op = OP_R; funct = F_ADD; OF = 1'b1; Zero = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (obs1 !== reset_out() || obs0 !== reset_out()) begin
                n_err++;
                $display("FAIL reset c=%0d: got %h/%h expected %h", c, obs1, obs0, reset_out());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs1 !== phase_out(P_FETCH, 6'd0, 1'b0) || obs0 !== phase_out(P_FETCH, 6'd0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_release: got %h/%h expected %h",
                     obs1, obs0, phase_out(P_FETCH, 6'd0, 1'b0));
        end
    endtask

    task automatic test_rtype_sub();
        int e1, w1, e0, w0, m1, p1;
        run_instr(OP_R, F_SUB, 0, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (w1 !== 1 || e1 !== 0) begin
            n_err++;
            $display("FAIL rtype_sub: reg_write cycles %0d exc cycles %0d, expected 1 and 0", w1, e1);
        end
    endtask

    task automatic test_overflow();
        int e1, w1, e0, w0, m1, p1;
        run_instr(OP_R, F_ADD, 1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (e1 !== 1 || w1 !== 0 || e0 !== 0 || w0 !== 1) begin
            n_err++;
            $display("FAIL add_ovf: exc %0d/%0d reg_write %0d/%0d, expected exc 1/0 reg_write 0/1",
                     e1, e0, w1, w0);
        end
        run_instr(OP_ADDI, 6'd0, 1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (e1 !== 1 || w1 !== 0 || e0 !== 0 || w0 !== 1) begin
            n_err++;
            $display("FAIL addi_ovf: exc %0d/%0d reg_write %0d/%0d, expected exc 1/0 reg_write 0/1",
                     e1, e0, w1, w0);
        end
        // OF is ignored for logic operations
        run_instr(OP_R, 6'b100101, 1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (e1 !== 0 || w1 !== 1) begin
            n_err++;
            $display("FAIL or_with_of: exc %0d reg_write %0d, expected 0 and 1", e1, w1);
        end
    endtask

    task automatic test_lw_sw();
        int e1, w1, e0, w0, m1, p1;
        run_instr(OP_LW, 6'd0, -1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (w1 !== 1 || m1 !== 0) begin
            n_err++;
            $display("FAIL lw: reg_write %0d mem_write %0d, expected 1 and 0", w1, m1);
        end
        run_instr(OP_SW, 6'd0, -1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (m1 !== 1 || w1 !== 0) begin
            n_err++;
            $display("FAIL sw: mem_write %0d reg_write %0d, expected 1 and 0", m1, w1);
        end
    endtask

    task automatic test_beq();
        int e1, w1, e0, w0, m1, p1;
        run_instr(OP_BEQ, 6'd0, -1, 1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (p1 !== 2) begin
            n_err++;
            $display("FAIL beq_taken: pc_write cycles %0d, expected 2", p1);
        end
        run_instr(OP_BEQ, 6'd0, -1, 0, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (p1 !== 1) begin
            n_err++;
            $display("FAIL beq_not_taken: pc_write cycles %0d, expected 1", p1);
        end
    endtask

    task automatic test_jump_illegal();
        int e1, w1, e0, w0, m1, p1;
        run_instr(OP_J, 6'd0, -1, -1, e1, w1, e0, w0, m1, p1);
        run_instr(6'b111111, 6'd0, -1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (e1 !== 1 || e0 !== 1 || w1 !== 0) begin
            n_err++;
            $display("FAIL illegal_op: exc %0d/%0d reg_write %0d, expected 1/1 and 0", e1, e0, w1);
        end
        run_instr(OP_R, 6'b000111, -1, -1, e1, w1, e0, w0, m1, p1);
        n_vec++;
        if (e1 !== 1 || e0 !== 1) begin
            n_err++;
            $display("FAIL bad_funct: exc %0d/%0d, expected 1/1", e1, e0);
        end
    endtask

    task automatic test_reset_mid();
        op = OP_LW; funct = 6'd0; OF = 1'b0; Zero = 1'b0;
        #1;
        @(negedge clk);               // now in DECODE
        @(negedge clk);               // now in MADR
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs1 !== reset_out() || mw1 !== 1'b0 || iord1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %h expected %h", obs1, reset_out());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs1 !== phase_out(P_FETCH, 6'd0, 1'b0) || obs0 !== phase_out(P_FETCH, 6'd0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_mid_refetch: got %h/%h expected %h",
                     obs1, obs0, phase_out(P_FETCH, 6'd0, 1'b0));
        end
    endtask

    task automatic test_random();
        int         e1, w1, e0, w0, m1, p1;
        logic [5:0] o, f;
        logic [5:0] legal_ops [6];
        logic [5:0] fl [7];
        legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        fl = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111, 6'b100110};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                o = 6'($urandom);
                while (op_legal(o)) o = 6'($urandom);
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            else                           f = fl[$urandom_range(0, 6)];
            run_instr(o, f, -1, -1, e1, w1, e0, w0, m1, p1);
        end
    endtask

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; OF = 1'b0; Zero = 1'b0;
        test_reset();
        test_rtype_sub();
        test_overflow();
        test_lw_sw();
        test_beq();
        test_jump_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mc_ctrl
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle main controller for the cpu1.0 datapath. It is the driving end of the ALU interface: it generates the 3-bit ALUCtrl code and the datapath mux and enable controls, and it consumes the ALU's Zero and OF flags. It sequences each instruction through fetch, decode, execute, memory and writeback, and raises an exception on arithmetic overflow or an illegal opcode. It sits between the instruction register (op/funct fields) and the shared PC/memory/regfile/ALU datapath.

Parameters:
EXC_ON_OVF, 1, 1 = signed overflow on add/sub/addi traps to EXC; 0 = OF is ignored and the result is written back.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag (combinational, same cycle)
OF  in  1  ALU overflow flag (combinational, same cycle)
ALUCtrl  out  3  ALU operation code (000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOT, 110 NOR, 111 XOR)
alu_src_a  out  1  0 = PC, 1 = regA
alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
pc_write  out  1  PC load enable (branch condition already folded in)
pc_src  out  2  00 = ALU out, 01 = ALUOut reg, 10 = jump target, 11 = exception vector
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_write  out  1  data memory write
ir_write  out  1  IR load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
exc  out  1  one-cycle exception pulse

Behaviour:
- Moore-style FSM with a 4-bit state register. Outputs decode combinationally from state, except ALUCtrl in EXEC (funct-dependent) and pc_write in BR (Zero-dependent).
- While rst=1: state <= FETCH, and all enables (pc_write, mem_write, ir_write, reg_write, exc) are forced to 0. Other outputs take FETCH values. Reset mid-instruction abandons that instruction; no write occurs in the rst cycle.
- Unlisted outputs are 0 in each state.
- FETCH: ir_write=1, alu_src_b=01, ALUCtrl=010, pc_src=00, pc_write=1. Next state is DECODE.
- DECODE: alu_src_b=11, ALUCtrl=010 (branch target into ALUOut). Next state by op:
  - 100011 lw or 101011 sw -> MADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BR
  - 001000 addi -> IEXEC
  - 000010 j -> JMP
  - any other op -> EXC
- MADR: alu_src_a=1, alu_src_b=10, ALUCtrl=010. lw -> MRD; sw -> MWR.
- MRD: iord=1. Next state is MWB.
- MWB: mem_to_reg=1, reg_write=1, reg_dst=0. Next state is FETCH.
- MWR: iord=1, mem_write=1. Next state is FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. ALUCtrl decodes from funct:
  - 100100 -> 000, 100101 -> 001, 100000 -> 010, 100010 -> 011
  - 101010 -> 100, 100111 -> 110, 100110 -> 111
  - unknown funct -> EXC
  - Otherwise, if EXC_ON_OVF and funct is add or sub and OF=1 -> EXC; else -> RWB.
- RWB: reg_dst=1, reg_write=1. Next state is FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, ALUCtrl=010. If EXC_ON_OVF and OF=1 -> EXC; else -> IWB.
- IWB: reg_dst=0, reg_write=1. Next state is FETCH.
- BR: alu_src_a=1, alu_src_b=00, ALUCtrl=011, pc_src=01, pc_write=Zero. Next state is FETCH.
- JMP: pc_src=10, pc_write=1. Next state is FETCH.
- EXC: exc=1, pc_src=11, pc_write=1, no reg/mem write. Next state is FETCH.
- OF is sampled only in EXEC (add/sub) and IEXEC. OF asserted in other states, or for logic ops, is ignored.
- Latency in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - trap: 4 for arithmetic overflow, 3 for illegal op
- Unreachable state encodings return to FETCH on the next edge.

Decomposition:
- Shared package mc_defs: opcode and funct constants, the ALUCtrl code constants (shared with the ALU), alu_src_b/pc_src selector encodings, and the state enumeration.
- One natural sub-module: alu_dec (funct -> ALUCtrl plus a funct_valid flag), used in EXEC.

Test Plan:
- Reset then release: rst=1 for 2 cycles -> all enables are 0. First cycle after release: state FETCH, ir_write=1, pc_write=1, ALUCtrl=010, alu_src_b=01.
- R-type sub, op=000000 funct=100010, OF=0 -> FETCH, DECODE, EXEC (ALUCtrl=011, alu_src_a=1, alu_src_b=00), RWB (reg_write=1, reg_dst=1), then FETCH. 4 cycles total.
- add with OF=1 in EXEC, EXC_ON_OVF=1 -> EXC with exc=1, pc_src=11, pc_write=1, and reg_write never 1. Repeat with EXC_ON_OVF=0 -> RWB writes.
- lw op=100011 -> 5 cycles. MRD has iord=1; MWB has mem_to_reg=1, reg_write=1. sw op=101011 -> 4 cycles with a single mem_write=1 cycle in MWR.
- beq op=000100: Zero=1 in BR -> pc_write=1, pc_src=01. Zero=0 -> pc_write=0. Each takes 3 cycles.
- Illegal op=111111 -> DECODE, EXC (exc=1), FETCH. rst asserted in MADR of lw -> no mem access, FETCH next.
